// File: rtl/convt1d_k1_ser.sv
// ============================================================================
// convt1d_k1_ser -- serialized 1-in / 2-out transposed 1x1 convolution
//
// Each accepted single-channel sample is multiplied by two fixed signed
// weights (W0 for channel 0, W1 for channel 1). Each full-precision product
// is arithmetically shifted right by SHIFT and wrapped to DATA_WIDTH bits.
// The two results are emitted one after the other on a single output
// stream: the channel-0 beat first, then the channel-1 beat.
//
// Ports
//   clk        in   1           rising-edge clock
//   rst        in   1           synchronous active-high reset
//   in_valid   in   1           din / in_last carry a sample
//   in_ready   out  1           block accepts a sample this cycle
//   din        in   DATA_WIDTH  signed input sample
//   in_last    in   1           last sample of a frame
//   out_valid  out  1           dout / dout_ch / out_last are valid
//   out_ready  in   1           downstream takes the current beat
//   dout       out  DATA_WIDTH  signed output beat
//   dout_ch    out  1           channel of the current beat
//   out_last   out  1           final beat of a frame (channel-1 beat only)
//
// Timing
//   Both results are computed from din and registered in the accept cycle,
//   so din may change freely afterwards. The channel-0 beat is presented in
//   the cycle after the accept. A new sample can be accepted in the same
//   cycle the channel-1 beat is taken, giving one input every two cycles
//   and one output beat every cycle when out_ready stays high.
// ============================================================================
module convt1d_k1_ser #(
    parameter int DATA_WIDTH = 16,
    parameter int W0         = 3,
    parameter int W1         = 5,
    parameter int SHIFT      = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         dout_ch,
    output logic                         out_last
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int NUM_CH     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CH0  = 2'd1,
        CH1  = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic in_hs;
    logic out_hs;
    logic last_reg;

    // Combinational per-channel results and their registered copies.
    logic signed [DATA_WIDTH-1:0] beat_calc [NUM_CH];
    logic signed [DATA_WIDTH-1:0] beat_q    [NUM_CH];

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    // ------------------------------------------------------------------------
    // Per-channel multiply, scale and result register
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam int WEIGHT = (gi == 0) ? W0 : W1;
            localparam logic signed [DATA_WIDTH-1:0] WEIGHT_C = DATA_WIDTH'(WEIGHT);

            logic signed [PROD_WIDTH-1:0] prod;
            logic signed [DATA_WIDTH-1:0] beat_reg;

            // Both operands are widened to the full product width first so the
            // multiply is exact; the shift is arithmetic (floor rounding) and
            // the final narrowing cast keeps bits [DATA_WIDTH+SHIFT-1:SHIFT],
            // i.e. the result wraps on overflow rather than saturating.
            assign prod            = PROD_WIDTH'(WEIGHT_C) * PROD_WIDTH'(din);
            assign beat_calc[gi]   = DATA_WIDTH'(prod >>> SHIFT);

            always_ff @(posedge clk) begin
                if (rst) begin
                    beat_reg <= '0;
                end else if (in_hs) begin
                    beat_reg <= beat_calc[gi];
                end
            end

            assign beat_q[gi] = beat_reg;
        end
    endgenerate

    // Frame marker travels with the sample; it only surfaces on the ch1 beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= 1'b0;
        end else if (in_hs) begin
            last_reg <= in_last;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // in_ready is held low during reset so that no handshake can complete
    // while the block is being cleared. In CH1 a new sample is only taken
    // when the ch1 beat leaves in the same cycle, so no result is overwritten
    // before it has been delivered.
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dout_ch   = 1'b0;
        dout      = '0;
        out_last  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = ~rst;
            end
            CH0: begin
                out_valid = 1'b1;
                dout      = beat_q[0];
            end
            CH1: begin
                in_ready  = out_ready & ~rst;
                out_valid = 1'b1;
                dout_ch   = 1'b1;
                dout      = beat_q[1];
                out_last  = last_reg;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_hs) begin
                    state_next = CH0;
                end
            end
            CH0: begin
                if (out_hs) begin
                    state_next = CH1;
                end
            end
            CH1: begin
                if (out_hs) begin
                    // Back-to-back pair: the new sample was loaded this cycle.
                    state_next = in_hs ? CH0 : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_convt1d_k1_ser.sv
// ============================================================================
// tb_convt1d_k1_ser -- self-checking bench for convt1d_k1_ser
//
// A monitor process keeps a queue of expected output beats built from every
// observed input handshake using plain integer arithmetic, and compares the
// DUT output against the queue head on every cycle out_valid is high.
// Delivered beats are also logged so directed tests can pin exact values.
// ============================================================================
module tb_convt1d_k1_ser;

    localparam int DW    = 16;
    localparam int W0    = 3;
    localparam int W1    = 5;
    localparam int SHIFT = 5;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] din;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] dout;
    logic                 dout_ch;
    logic                 out_last;

    convt1d_k1_ser #(
        .DATA_WIDTH(DW),
        .W0        (W0),
        .W1        (W1),
        .SHIFT     (SHIFT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din      (din),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .dout_ch  (dout_ch),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit     ch;
        longint data;
        bit     last;
    } beat_t;

    beat_t exp_q[$];
    beat_t log_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact product, floor division by 2^SHIFT, wrap to DW bits.
    function automatic longint model_beat(input int w, input longint d);
        longint p;
        logic signed [DW-1:0] r;
        p = longint'(w) * d;
        p = p >>> SHIFT;
        r = p[DW-1:0];
        return longint'(r);
    endfunction

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                check("in_ready_in_reset", in_ready, 0);
            end else begin
                if (out_valid) begin
                    check("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        check("dout_ch", dout_ch, exp_q[0].ch);
                        check("dout", $signed(dout), exp_q[0].data);
                        check("out_last", out_last, exp_q[0].last);
                        if (out_ready) begin
                            beat_t b;
                            b.ch   = dout_ch;
                            b.data = $signed(dout);
                            b.last = out_last;
                            log_q.push_back(b);
                            $display("beat #%0d ch=%0d data=%0d last=%0d",
                                     log_q.size() - 1, b.ch, b.data, b.last);
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    beat_t b0;
                    beat_t b1;
                    b0.ch   = 1'b0;
                    b0.data = model_beat(W0, $signed(din));
                    b0.last = 1'b0;
                    b1.ch   = 1'b1;
                    b1.data = model_beat(W1, $signed(din));
                    b1.last = in_last;
                    exp_q.push_back(b0);
                    exp_q.push_back(b1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------------
    task automatic send(input logic signed [DW-1:0] d, input logic l);
        int n;
        n        = 0;
        in_valid = 1'b1;
        din      = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din      = 16'sh5a5a;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        bit ir_log [17];
        bit ov_log [17];
        logic signed [DW-1:0] samp [8];
        int k;
        int ov_cnt;

        rst       = 1'b1;
        in_valid  = 1'b0;
        din       = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_dout", $signed(dout), 0);
        check("reset_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);

        // T1: basic pair and one-cycle latency
        send(16'sd64, 1'b0);
        check("t1_lat_valid", out_valid, 1);
        check("t1_lat_ch", dout_ch, 0);
        check("t1_lat_dout", $signed(dout), 6);
        drain();

        // T2: floor rounding on negatives (second send overlaps ch1 beat)
        send(-16'sd64, 1'b0);
        send(-16'sd1, 1'b1);
        drain();

        // T3: extremes
        send(16'sd32767, 1'b0);
        send(-16'sd32768, 1'b1);
        drain();

        // T4: sustained throughput, 8 samples back to back
        for (int i = 0; i < 8; i++) samp[i] = DW'(32 * (i + 1));
        k = 0;
        for (int c = 0; c < 17; c++) begin
            in_valid = (k < 8);
            din      = (k < 8) ? samp[k] : '0;
            in_last  = (k == 7);
            @(negedge clk);
            ir_log[c] = in_ready;
            ov_log[c] = out_valid;
            if (in_valid && in_ready) k++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("t4_accepted", k, 8);
        check("t4_first_ov", ov_log[0], 0);
        ov_cnt = 0;
        for (int c = 1; c < 17; c++) ov_cnt += ov_log[c];
        check("t4_beats_consecutive", ov_cnt, 16);
        for (int c = 0; c < 16; c++) begin
            check($sformatf("t4_in_ready_c%0d", c), ir_log[c], (c % 2 == 0));
        end
        drain();

        // T5: stall in CH0 then in CH1
        out_ready = 1'b0;
        send(16'sd100, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t5_ch0_valid", out_valid, 1);
            check("t5_ch0_dout", $signed(dout), 9);
            check("t5_ch0_ch", dout_ch, 0);
            check("t5_ch0_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t5_ch1_valid", out_valid, 1);
            check("t5_ch1_dout", $signed(dout), 15);
            check("t5_ch1_ch", dout_ch, 1);
            check("t5_ch1_last", out_last, 1);
            check("t5_ch1_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // T6: reset while in CH1 discards the pending beat
        out_ready = 1'b0;
        send(16'sd200, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("t6_in_ch1", dout_ch, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_dout", $signed(dout), 0);
        check("t6_rst_ch", dout_ch, 0);
        check("t6_rst_last", out_last, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("t6_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(16'sd64, 1'b1);
        drain();

        // Literal pins on the delivered beat log
        check("log_size", log_q.size(), 31);
        if (log_q.size() >= 31) begin
            check("log0_t1_ch0", log_q[0].data, 6);
            check("log1_t1_ch1", log_q[1].data, 10);
            check("log2_neg64_ch0", log_q[2].data, -6);
            check("log3_neg64_ch1", log_q[3].data, -10);
            check("log4_neg1_ch0", log_q[4].data, -1);
            check("log5_neg1_ch1", log_q[5].data, -1);
            check("log6_max_ch0", log_q[6].data, 3071);
            check("log7_max_ch1", log_q[7].data, 5119);
            check("log8_min_ch0", log_q[8].data, -3072);
            check("log9_min_ch1", log_q[9].data, -5120);
            check("log10_t4_first", log_q[10].data, 3);
            check("log25_t4_last", log_q[25].data, 40);
            check("log25_t4_lastflag", log_q[25].last, 1);
            check("log26_stall_ch0", log_q[26].data, 9);
            check("log27_stall_ch1", log_q[27].data, 15);
            check("log28_pre_rst_ch0", log_q[28].data, 18);
            check("log29_post_rst_ch", log_q[29].ch, 0);
            check("log29_post_rst_data", log_q[29].data, 6);
            check("log29_post_rst_last", log_q[29].last, 0);
            check("log30_post_rst_ch", log_q[30].ch, 1);
            check("log30_post_rst_data", log_q[30].data, 10);
            check("log30_post_rst_last", log_q[30].last, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
